// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Responder end of the cache bus. Serves dcache (dREN/dWEN) and icache
//   (iREN) word requests onto a single shared RAM port.
//     - dcache has priority over icache.
//     - After the even word of a 2-word dcache block completes, the bus
//       stays reserved for the dcache for LOCK_CYC cycles so that the odd
//       word can follow without the icache slipping in.
//     - After MAX_DGRANT consecutive dcache grants, a waiting icache request
//       is forced through ahead of the dcache.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   dREN, dWEN, daddr, dstore dcache request, word address, write data
//   dwait, dload              dcache handshake (0 = done) and read data
//   iREN, iaddr               icache request and word address
//   iwait, iload              icache handshake (0 = done) and read data
//   ramREN, ramWEN            RAM read / write strobes
//   ramaddr, ramstore         RAM address / write data
//   ramload, ram_rdy          RAM read data / access-complete
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned LOCK_CYC   = 4,
  parameter int unsigned MAX_DGRANT = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_rdy
);

  localparam int unsigned LW = $clog2(LOCK_CYC + 1);
  localparam int unsigned DW = $clog2(MAX_DGRANT + 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYC - 1);
  localparam logic [DW-1:0] DGRANT_MAX = DW'(MAX_DGRANT);

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    DLOCK,
    IACC
  } state_t;

  state_t          state_q,  state_d;
  logic [LW-1:0]   lock_q,   lock_d;
  logic [DW-1:0]   dgrant_q, dgrant_d;
  logic            dreq;

  assign dreq = dREN | dWEN;

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    dgrant_d = dgrant_q;
    unique case (state_q)
      IDLE: begin
        // Starvation tracking only matters while an icache request waits.
        if (!iREN) dgrant_d = '0;
        if (dreq && !(iREN && (dgrant_q == DGRANT_MAX))) state_d = DACC;
        else if (iREN)                                  state_d = IACC;
      end
      DACC: begin
        if (!dreq) begin
          state_d = IDLE;
        end else if (ram_rdy) begin
          if (dgrant_q != DGRANT_MAX) dgrant_d = dgrant_q + 1'b1;
          // Even word of a block: hold the bus for the odd word.
          if (!daddr[2]) begin
            state_d = DLOCK;
            lock_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DLOCK: begin
        if (dreq) begin
          state_d = DACC;
        end else begin
          lock_d = lock_q + 1'b1;
          if (lock_q == LOCK_LAST) state_d = IDLE;
        end
      end
      IACC: begin
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_rdy) begin
          state_d  = IDLE;
          dgrant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      lock_q   <= '0;
      dgrant_q <= '0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      dgrant_q <= dgrant_d;
    end
  end

  // Bus outputs are decoded from the registered state; the request inputs
  // gate the strobes so an abandoned access drops them in the same cycle.
  always_comb begin
    dwait    = 1'b1;
    iwait    = 1'b1;
    dload    = '0;
    iload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        dwait    = ~(dreq & ram_rdy);
      end
      IACC: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        iwait   = ~(iREN & ram_rdy);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int LOCK = 4;
  localparam int MAXG = 8;

  typedef struct packed {
    logic        dren, dwen, iren, rdy;
    logic [31:0] daddr, dstore, iaddr, ramload;
  } in_t;

  typedef struct packed {
    logic        dwait, iwait, rren, rwen;
    logic [31:0] addr, store, dload, iload;
  } out_t;

  typedef struct packed {
    in_t  vi;
    out_t vo;
  } vec_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dREN = 1'b0, dWEN = 1'b0, iREN = 1'b0, ram_rdy = 1'b0;
  logic [31:0] daddr = '0, dstore = '0, iaddr = '0, ramload = '0;
  logic        dwait, iwait, ramREN, ramWEN;
  logic [31:0] dload, iload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  // Reference model: which requester owns the bus, remaining reservation
  // cycles after an even block word, and the run of back-to-back dcache grants.
  bit m_dbusy, m_ibusy;
  int m_hold, m_streak;

  logic        obs_dwait, obs_iwait, obs_rwen, obs_rren;
  logic [31:0] obs_addr;

  mem_arbiter #(.LOCK_CYC(LOCK), .MAX_DGRANT(MAXG)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_rdy(ram_rdy)
  );

  always #5 CLK = ~CLK;

  function automatic in_t mkin(input logic dr, input logic dw, input logic ir, input logic rd,
                               input logic [31:0] da, input logic [31:0] ds,
                               input logic [31:0] ia, input logic [31:0] rl);
    in_t v;
    v.dren = dr; v.dwen = dw; v.iren = ir; v.rdy = rd;
    v.daddr = da; v.dstore = ds; v.iaddr = ia; v.ramload = rl;
    return v;
  endfunction

  function automatic out_t mkout(input logic dw, input logic iw, input logic rr, input logic rw,
                                 input logic [31:0] a, input logic [31:0] s,
                                 input logic [31:0] dl, input logic [31:0] il);
    out_t o;
    o.dwait = dw; o.iwait = iw; o.rren = rr; o.rwen = rw;
    o.addr = a; o.store = s; o.dload = dl; o.iload = il;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, ".dwait"},    32'(dwait),    32'(e.dwait));
    chk({tag, ".iwait"},    32'(iwait),    32'(e.iwait));
    chk({tag, ".ramREN"},   32'(ramREN),   32'(e.rren));
    chk({tag, ".ramWEN"},   32'(ramWEN),   32'(e.rwen));
    chk({tag, ".ramaddr"},  ramaddr,       e.addr);
    chk({tag, ".ramstore"}, ramstore,      e.store);
    chk({tag, ".dload"},    dload,         e.dload);
    chk({tag, ".iload"},    iload,         e.iload);
  endtask

  function automatic out_t model_eval(input in_t v);
    out_t o;
    o = '0;
    o.dwait = 1'b1;
    o.iwait = 1'b1;
    if (m_dbusy) begin
      o.rwen  = v.dwen;
      o.rren  = v.dren & ~v.dwen;
      o.addr  = v.daddr;
      o.store = v.dstore;
      o.dload = v.ramload;
      o.dwait = ~((v.dren | v.dwen) & v.rdy);
    end else if (m_ibusy) begin
      o.rren  = v.iren;
      o.addr  = v.iaddr;
      o.iload = v.ramload;
      o.iwait = ~(v.iren & v.rdy);
    end
    return o;
  endfunction

  task automatic model_next(input in_t v);
    bit dreq;
    dreq = v.dren | v.dwen;
    if (m_dbusy) begin
      if (!dreq) m_dbusy = 0;
      else if (v.rdy) begin
        m_dbusy = 0;
        if (m_streak < MAXG) m_streak++;
        if (!v.daddr[2]) m_hold = LOCK;
      end
    end else if (m_ibusy) begin
      if (v.iren && v.rdy) m_streak = 0;
      if (!v.iren || v.rdy) m_ibusy = 0;
    end else if (m_hold > 0) begin
      if (dreq) begin
        m_hold  = 0;
        m_dbusy = 1;
      end else m_hold--;
    end else begin
      if (!v.iren) m_streak = 0;
      if (dreq && !(v.iren && m_streak >= MAXG)) m_dbusy = 1;
      else if (v.iren) m_ibusy = 1;
    end
  endtask

  task automatic drive(input in_t v);
    @(negedge CLK);
    dREN = v.dren; dWEN = v.dwen; iREN = v.iren; ram_rdy = v.rdy;
    daddr = v.daddr; dstore = v.dstore; iaddr = v.iaddr; ramload = v.ramload;
    #1;
  endtask

  task automatic cycle(input in_t v, input string tag);
    out_t e;
    drive(v);
    e = model_eval(v);
    check_out(tag, e);
    obs_dwait = dwait; obs_iwait = iwait; obs_rwen = ramWEN; obs_rren = ramREN; obs_addr = ramaddr;
    model_next(v);
    @(posedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    dREN = 0; dWEN = 0; iREN = 0; ram_rdy = 0;
    daddr = '0; dstore = '0; iaddr = '0; ramload = '0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    m_dbusy = 0; m_ibusy = 0; m_hold = 0; m_streak = 0;
  endtask

  vec_t tab[10];
  out_t idle_o;

  initial begin
    int dcomp, icomp, nwr, gap, first;
    in_t v;

    idle_o = mkout(1, 1, 0, 0, 0, 0, 0, 0);

    // Reset values, observed while reset is asserted with requests present.
    nRST = 1'b0;
    dREN = 1; iREN = 1; ram_rdy = 1; daddr = 32'h40; ramload = 32'h1111;
    #3;
    check_out("reset", idle_o);
    do_reset();

    // Directed vectors: single read with 3-cycle RAM latency, block pair, icache fetch.
    tab[0] = '{mkin(1,0,0,0,32'h40,0,0,0),           idle_o};
    tab[1] = '{mkin(1,0,0,0,32'h40,0,0,0),           mkout(1,1,1,0,32'h40,0,0,0)};
    tab[2] = '{mkin(1,0,0,0,32'h40,0,0,0),           mkout(1,1,1,0,32'h40,0,0,0)};
    tab[3] = '{mkin(1,0,0,1,32'h40,0,0,32'hDEADBEEF), mkout(0,1,1,0,32'h40,0,32'hDEADBEEF,0)};
    tab[4] = '{mkin(0,0,0,0,0,0,0,0),                idle_o};
    tab[5] = '{mkin(1,0,0,1,32'h44,0,0,0),           idle_o};
    tab[6] = '{mkin(1,0,0,1,32'h44,0,0,32'h55),      mkout(0,1,1,0,32'h44,0,32'h55,0)};
    tab[7] = '{mkin(0,0,1,0,0,0,32'h300,0),          idle_o};
    tab[8] = '{mkin(0,0,1,1,0,0,32'h300,32'h77),     mkout(1,0,1,0,32'h300,0,0,32'h77)};
    tab[9] = '{mkin(0,0,0,0,0,0,0,0),                idle_o};
    for (int i = 0; i < 10; i++) begin
      drive(tab[i].vi);
      check_out($sformatf("tab%0d", i), tab[i].vo);
      model_next(tab[i].vi);
      @(posedge CLK);
    end

    // Block write pair with icache held waiting.
    do_reset();
    nwr = 0; icomp = 0;
    for (int i = 0; i < 4; i++) begin
      v = mkin(0, 1, 1, 1, (i < 2) ? 32'h80 : 32'h84, (i < 2) ? 32'h1234 : 32'h5678, 32'h500, 0);
      cycle(v, "wr");
      if (obs_rwen) nwr++;
      if (!obs_iwait) icomp++;
    end
    chk("wr.count", nwr, 2);
    chk("wr.iwait_held", icomp, 0);
    for (int i = 0; i < 2; i++) cycle(mkin(0, 0, 1, 1, 0, 0, 32'h500, 32'h9), "wr.ifetch");
    chk("wr.ifetch_done", 32'(obs_iwait), 0);

    // Simultaneous requests: dcache block first, then icache.
    do_reset();
    cycle(mkin(1, 0, 1, 1, 32'h100, 0, 32'h600, 1), "pri");
    cycle(mkin(1, 0, 1, 1, 32'h100, 0, 32'h600, 1), "pri");
    chk("pri.first_addr", obs_addr, 32'h100);
    cycle(mkin(1, 0, 1, 1, 32'h104, 0, 32'h600, 2), "pri");
    cycle(mkin(1, 0, 1, 1, 32'h104, 0, 32'h600, 2), "pri");
    chk("pri.second_addr", obs_addr, 32'h104);
    cycle(mkin(0, 0, 1, 1, 0, 0, 32'h600, 3), "pri");
    cycle(mkin(0, 0, 1, 1, 0, 0, 32'h600, 3), "pri");
    chk("pri.icache_after", 32'(obs_iwait), 0);

    // Starvation guard: icache forced through after MAX_DGRANT dcache grants.
    do_reset();
    dcomp = 0; first = 999;
    for (int i = 0; i < 40 && first == 999; i++) begin
      cycle(mkin(1, 0, 1, 1, 32'h104, 0, 32'h700, i), "starve");
      if (!obs_iwait) first = dcomp;
      if (!obs_dwait) dcomp++;
    end
    chk("starve.dgrants_before_i", first, MAXG);

    // Lock window expiry with pending icache.
    do_reset();
    cycle(mkin(1, 0, 1, 1, 32'h200, 0, 32'h800, 0), "lock");
    cycle(mkin(1, 0, 1, 1, 32'h200, 0, 32'h800, 0), "lock");
    chk("lock.dcomplete", 32'(obs_dwait), 0);
    gap = 999;
    for (int n = 1; n <= 20 && gap == 999; n++) begin
      cycle(mkin(0, 0, 1, 1, 0, 0, 32'h800, 32'hAB), "lock");
      if (!obs_iwait) gap = n;
    end
    chk("lock.gap", gap, LOCK + 2);

    // Reset during a write access.
    do_reset();
    cycle(mkin(0, 1, 0, 0, 32'h88, 32'hCAFE, 0, 0), "rst_mid");
    drive(mkin(0, 1, 0, 0, 32'h88, 32'hCAFE, 0, 0));
    chk("rst_mid.wen_before", 32'(ramWEN), 1);
    #1 nRST = 1'b0;
    #1;
    chk("rst_mid.wen", 32'(ramWEN), 0);
    chk("rst_mid.dwait", 32'(dwait), 1);
    chk("rst_mid.addr", ramaddr, 0);

    // Dropped dcache request aborts.
    do_reset();
    cycle(mkin(1, 0, 0, 0, 32'h48, 0, 0, 0), "abort");
    cycle(mkin(1, 0, 0, 0, 32'h48, 0, 0, 0), "abort");
    cycle(mkin(0, 0, 0, 0, 32'h48, 0, 0, 0), "abort");
    chk("abort.strobe_low", 32'(obs_rren), 0);
    cycle(mkin(1, 0, 0, 1, 32'h48, 0, 0, 0), "abort");
    chk("abort.idle_next", 32'(obs_rren), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      v.dren    = ($urandom_range(2) != 0);
      v.dwen    = ($urandom_range(3) == 0);
      v.iren    = ($urandom_range(2) != 0);
      v.rdy     = ($urandom_range(4) < 2);
      v.daddr   = $urandom & 32'hFFFF_FFFC;
      v.dstore  = $urandom;
      v.iaddr   = $urandom;
      v.ramload = $urandom;
      cycle(v, "rand");
      checks++;
      if (obs_rren && obs_rwen) begin
        errors++;
        $display("FAIL rand.both_strobes actual=11 required=not11 t=%0t", $time);
      end
      checks++;
      if (!obs_dwait && !obs_iwait) begin
        errors++;
        $display("FAIL rand.both_waits_low actual=00 required=not00 t=%0t", $time);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
